// File: rtl/processador_multiciclo_if.sv
// Instruction-fetch and data-memory bus of the multicycle core.
// The core is the master on both channels; memories answer with ack.
interface processador_multiciclo_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/processador_multiciclo.sv
// Four-register multicycle core: FETCH -> EXEC (-> MEM) -> FETCH, HLT parks in HALT.
// 8-bit instructions op[7:4] ra[3:2] rb[1:0]; all outputs come straight from flops.
module processador_multiciclo #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    processador_multiciclo_if.master bus,
    output logic                     halted,
    output logic [15:0]              instret
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t                  state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d, rjump_q, rjump_d;
    logic [3:0][DATA_W-1:0]  regs_q, regs_d;
    logic [7:0]              ir_q, ir_d;
    logic [15:0]             instret_q, instret_d;
    logic                    halted_q, halted_d;
    logic                    imem_req_q, imem_req_d;
    logic                    dmem_req_q, dmem_req_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0]       dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]       dmem_wdata_q, dmem_wdata_d;

    logic [3:0]        op;
    logic [1:0]        ra, rb;
    logic [DATA_W-1:0] va, vb, imm, alu;
    logic [PC_W-1:0]   pc_inc;
    logic [15:0]       instret_inc;

    assign op          = ir_q[7:4];
    assign ra          = ir_q[3:2];
    assign rb          = ir_q[1:0];
    assign va          = regs_q[ra];
    assign vb          = regs_q[rb];
    assign imm         = DATA_W'(ir_q[3:0]);
    assign pc_inc      = pc_q + PC_W'(1);
    assign instret_inc = instret_q + 16'd1;

    // rb doubles as the 2-bit shift amount for SLL/SRL
    always_comb begin
        alu = va;
        case (op)
            4'h0:    alu = va + vb;
            4'h1:    alu = va - vb;
            4'h2:    alu = va & vb;
            4'h3:    alu = va | vb;
            4'h4:    alu = va ^ vb;
            4'h7:    alu = va << rb;
            4'h8:    alu = va >> rb;
            default: alu = va;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rjump_d      = rjump_q;
        regs_d       = regs_q;
        ir_d         = ir_q;
        instret_d    = instret_q;
        halted_d     = halted_q;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            S_FETCH: begin
                // req is low only on the first cycle after reset; an ack then is ignored
                if (imem_req_q && bus.imem_ack) begin
                    ir_d       = bus.imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_EXEC;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b1;
                pc_d       = pc_inc;
                instret_d  = instret_inc;
                case (op)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8: regs_d[ra] = alu;
                    4'h5: regs_d[0] = imm;
                    4'h6: regs_d[0] = regs_q[0] + imm;
                    4'h9, 4'hA: begin
                        state_d      = S_MEM;
                        imem_req_d   = 1'b0;
                        pc_d         = pc_q;
                        instret_d    = instret_q;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = (op == 4'hA);
                        dmem_addr_d  = vb;
                        dmem_wdata_d = va;
                    end
                    4'hB: rjump_d = PC_W'(vb);
                    4'hC: if (va == vb) pc_d = rjump_q;
                    4'hD: if (va != vb) pc_d = rjump_q;
                    4'hE: pc_d = rjump_q;
                    default: begin
                        state_d    = S_HALT;
                        imem_req_d = 1'b0;
                        pc_d       = pc_q;
                        halted_d   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_q && bus.dmem_ack) begin
                    if (!dmem_we_q) regs_d[ra] = bus.dmem_rdata;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    pc_d       = pc_inc;
                    instret_d  = instret_inc;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            rjump_q      <= '0;
            regs_q       <= '0;
            ir_q         <= '0;
            instret_q    <= '0;
            halted_q     <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rjump_q      <= rjump_d;
            regs_q       <= regs_d;
            ir_q         <= ir_d;
            instret_q    <= instret_d;
            halted_q     <= halted_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign halted         = halted_q;
    assign instret        = instret_q;
endmodule
